// File: rtl/sdram_rd_checker.sv
// Read-side pattern checker for the FIFO-wrapped SDRAM controller.
// Drains TEST_LEN words per pass and compares each one against {~idx, idx}.
module sdram_rd_checker #(
  parameter logic [23:0] TEST_LEN   = 24'h400000,
  parameter logic [15:0] SETTLE_CYC = 16'd1000,
  parameter bit          LOOP       = 1'b1
) (
  input  logic        clk_50m,
  input  logic        rst,
  input  logic        sdram_init_done,
  input  logic        hold,
  output logic        rd_en,
  input  logic [63:0] rd_data,
  output logic        error_flag,
  output logic [15:0] err_count,
  output logic [23:0] first_err_idx,
  output logic        pass_done,
  output logic [3:0]  cycle_countor
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [23:0] LAST_IDX = TEST_LEN - 24'd1;
  localparam logic [15:0] SET_LAST = SETTLE_CYC - 16'd1;

  state_t      state_q, state_d;
  logic [23:0] idx_q, idx_d;
  logic [15:0] set_q, set_d;
  logic        cmp_vld_q, cmp_vld_d;
  logic [63:0] exp_q, exp_d;
  logic [23:0] cmp_idx_q, cmp_idx_d;
  logic        error_flag_q, error_flag_d;
  logic [15:0] err_count_q, err_count_d;
  logic [23:0] first_err_q, first_err_d;
  logic        pass_done_q, pass_done_d;
  logic [3:0]  cyc_q, cyc_d;

  logic settle_end;
  logic mismatch;
  logic done_enter;

  function automatic logic [63:0] exp_word(input logic [23:0] i);
    logic [31:0] e;
    e = {8'd0, i};
    return {~e, e};
  endfunction

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      set_q        <= '0;
      cmp_vld_q    <= 1'b0;
      exp_q        <= '0;
      cmp_idx_q    <= '0;
      error_flag_q <= 1'b0;
      err_count_q  <= '0;
      first_err_q  <= '0;
      pass_done_q  <= 1'b0;
      cyc_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      set_q        <= set_d;
      cmp_vld_q    <= cmp_vld_d;
      exp_q        <= exp_d;
      cmp_idx_q    <= cmp_idx_d;
      error_flag_q <= error_flag_d;
      err_count_q  <= err_count_d;
      first_err_q  <= first_err_d;
      pass_done_q  <= pass_done_d;
      cyc_q        <= cyc_d;
    end
  end

  // SETTLE_CYC of 0 behaves like 1: a single WAIT cycle.
  assign settle_end = (SETTLE_CYC == 16'd0) || (set_q == SET_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (sdram_init_done) state_d = S_WAIT;
      S_WAIT:  if (settle_end) state_d = S_READ;
      S_READ:  if (rd_en && idx_q == LAST_IDX) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  if (LOOP) state_d = S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en = (state_q == S_READ) && !hold;
  end

  always_comb begin
    idx_d     = idx_q;
    set_d     = set_q;
    cmp_vld_d = rd_en;
    exp_d     = exp_q;
    cmp_idx_d = cmp_idx_q;
    unique case (1'b1)
      state_q == S_WAIT: begin
        set_d = set_q + 16'd1;
        idx_d = '0;
      end
      state_q == S_READ: begin
        if (rd_en) begin
          exp_d     = exp_word(idx_q);
          cmp_idx_d = idx_q;
          idx_d     = idx_q + 24'd1;
        end
      end
      state_q == S_DONE: begin
        set_d = '0;
        idx_d = '0;
      end
      default: set_d = '0;
    endcase
  end

  assign mismatch   = cmp_vld_q && (rd_data != exp_q);
  assign done_enter = (state_d == S_DONE) && (state_q != S_DONE);

  always_comb begin
    error_flag_d = error_flag_q | mismatch;
    err_count_d  = err_count_q;
    first_err_d  = first_err_q;
    if (mismatch && err_count_q != 16'hFFFF)
      err_count_d = err_count_q + 16'd1;
    if (mismatch && !error_flag_q)
      first_err_d = cmp_idx_q;
    pass_done_d = done_enter;
    cyc_d       = cyc_q + {3'd0, done_enter};
  end

  assign error_flag    = error_flag_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_q;
  assign pass_done     = pass_done_q;
  assign cycle_countor = cyc_q;

endmodule

// File: tb/tb_sdram_rd_checker.sv
// Directed bench for sdram_rd_checker: short looping instance
// plus a long non-looping instance that saturates the error count.
module tb_sdram_rd_checker;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst, init, hold;
  logic        rd_en;
  logic [63:0] rd_data;
  logic        error_flag;
  logic [15:0] err_count;
  logic [23:0] first_err_idx;
  logic        pass_done;
  logic [3:0]  cyc;

  logic        rst_l, init_l, hold_l;
  logic        rd_en_l;
  logic [63:0] rd_data_l;
  logic        error_flag_l;
  logic [15:0] err_count_l;
  logic [23:0] first_err_idx_l;
  logic        pass_done_l;
  logic [3:0]  cyc_l;

  int errs = 0;
  int checks = 0;
  int bad_a = -1;
  int bad_b = -1;
  int widx;
  int en_cnt_l;

  sdram_rd_checker #(
    .TEST_LEN(24'd16), .SETTLE_CYC(16'd4), .LOOP(1'b1)
  ) dut (
    .clk_50m(clk), .rst(rst), .sdram_init_done(init), .hold(hold),
    .rd_en(rd_en), .rd_data(rd_data), .error_flag(error_flag),
    .err_count(err_count), .first_err_idx(first_err_idx),
    .pass_done(pass_done), .cycle_countor(cyc)
  );

  sdram_rd_checker #(
    .TEST_LEN(24'd70000), .SETTLE_CYC(16'd0), .LOOP(1'b0)
  ) dut_l (
    .clk_50m(clk), .rst(rst_l), .sdram_init_done(init_l), .hold(hold_l),
    .rd_en(rd_en_l), .rd_data(rd_data_l), .error_flag(error_flag_l),
    .err_count(err_count_l), .first_err_idx(first_err_idx_l),
    .pass_done(pass_done_l), .cycle_countor(cyc_l)
  );

  function automatic logic [63:0] pat(input int i);
    logic [31:0] e;
    e = 32'(i) & 32'h00FF_FFFF;
    return {~e, e};
  endfunction

  // FIFO model: word valid one cycle after rd_en, optional corruption
  always @(posedge clk) begin
    if (rst) begin
      widx <= 0;
    end else if (rd_en) begin
      rd_data <= pat(widx)
               ^ ((widx == bad_a) ? 64'h1 : 64'h0)
               ^ ((widx == bad_b) ? 64'h100_0000_0000 : 64'h0);
      widx <= (widx == 15) ? 0 : widx + 1;
    end
  end

  always @(posedge clk) begin
    if (rst_l) en_cnt_l <= 0;
    else if (rd_en_l) en_cnt_l <= en_cnt_l + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_first_en(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!rd_en && n < 100);
  endtask

  task automatic run_pass(output int en);
    en = 0;
    for (int k = 0; k < 200; k++) begin
      if (rd_en) en++;
      if (pass_done) break;
      tick();
    end
  endtask

  initial begin
    int n, en, last, pd;
    rst = 1; init = 0; hold = 0;
    rst_l = 1; init_l = 0; hold_l = 0;
    rd_data_l = 64'h0;
    tick(); tick();
    chk("rst_rd_en", rd_en, 0);
    chk("rst_err_flag", error_flag, 0);
    chk("rst_err_cnt", err_count, 0);
    chk("rst_first_idx", first_err_idx, 0);
    chk("rst_pass_done", pass_done, 0);
    chk("rst_cyc", cyc, 0);

    // clean pass
    init = 1;
    tick();
    rst = 0;
    wait_first_en(n);
    chk("first_en_lat", n, 5);
    run_pass(en);
    chk("p1_pass_done", pass_done, 1);
    chk("p1_en_cnt", en, 16);
    chk("p1_cyc", cyc, 1);
    chk("p1_err_flag", error_flag, 0);
    chk("p1_err_cnt", err_count, 0);

    // corrupt words 5 and 9
    rst = 1; bad_a = 5; bad_b = 9;
    tick();
    rst = 0;
    n = 0;
    for (int k = 0; k < 100 && n < 6; k++) begin
      tick();
      if (rd_en) n++;
    end
    chk("w5_reached", n, 6);
    tick();
    chk("err_t1", error_flag, 0);
    tick();
    chk("err_t2", error_flag, 1);
    chk("err_t2_cnt", err_count, 1);
    for (int k = 0; k < 100 && !pass_done; k++) tick();
    chk("c_pass_done", pass_done, 1);
    chk("c_err_cnt", err_count, 2);
    chk("c_first_idx", first_err_idx, 5);

    // hold toggling
    rst = 1; bad_a = -1; bad_b = -1;
    tick();
    rst = 0;
    wait_first_en(n);
    en = 1; last = 0;
    for (int c = 1; c < 200; c++) begin
      @(posedge clk);
      #1;
      hold = (c % 2 == 1);
      #1;
      if (rd_en) begin
        en++;
        last = c;
      end
      if (pass_done) break;
    end
    hold = 0;
    chk("h_pass_done", pass_done, 1);
    chk("h_en_cnt", en, 16);
    chk("h_read_span", last + 1, 31);
    chk("h_err_cnt", err_count, 0);
    chk("h_err_flag", error_flag, 0);

    // 17 looping passes, error injected in pass 2
    #1;
    rst = 1;
    tick();
    rst = 0;
    pd = 0;
    for (int k = 0; k < 3000 && pd < 17; k++) begin
      tick();
      if (pass_done) begin
        pd++;
        if (pd == 1) begin
          chk("l_p1_clean", error_flag, 0);
          bad_a = 3;
        end
        if (pd == 2) bad_a = -1;
        if (pd >= 2) chk("l_sticky", error_flag, 1);
      end
    end
    chk("l_pass_cnt", pd, 17);
    chk("l_cyc_wrap", cyc, 1);
    chk("l_err_cnt", err_count, 1);
    chk("l_first_idx", first_err_idx, 3);

    // reset mid-READ with word 6 corrupt still in the compare stage
    rst = 1; bad_a = 6;
    tick();
    rst = 0;
    n = 0;
    for (int k = 0; k < 100 && n < 7; k++) begin
      tick();
      if (rd_en) n++;
    end
    tick();
    chk("r_pre_en", rd_en, 1);
    rst = 1;
    tick();
    chk("r_rd_en", rd_en, 0);
    chk("r_err_flag", error_flag, 0);
    chk("r_err_cnt", err_count, 0);
    chk("r_first_idx", first_err_idx, 0);
    chk("r_pass_done", pass_done, 0);
    chk("r_cyc", cyc, 0);
    bad_a = -1;
    tick();
    rst = 0;
    wait_first_en(n);
    chk("r_first_en_lat", n, 5);
    run_pass(en);
    chk("r_pass_done2", pass_done, 1);
    chk("r_en_cnt", en, 16);
    chk("r_err_flag2", error_flag, 0);
    chk("r_cyc2", cyc, 1);

    // long run, every word wrong, LOOP=0
    init_l = 1;
    tick();
    rst_l = 0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!rd_en_l && n < 10);
    chk("s_first_en_lat", n, 2);
    for (int k = 0; k < 80000 && !pass_done_l; k++) tick();
    chk("s_pass_done", pass_done_l, 1);
    chk("s_en_cnt", en_cnt_l, 70000);
    chk("s_err_cnt_sat", err_count_l, 16'hFFFF);
    chk("s_first_idx", first_err_idx_l, 0);
    chk("s_err_flag", error_flag_l, 1);
    chk("s_cyc", cyc_l, 1);
    tick();
    chk("s_done_once", pass_done_l, 0);
    tick();
    chk("s_stop_rd_en", rd_en_l, 0);
    chk("s_cyc_hold", cyc_l, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
